// File: rtl/clock_cal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_cal_pkg
// Brief    : Shared widths, month constants and leap rule for the calendar.
// Revision : 1.0 - initial release
// ============================================================================
package clock_cal_pkg;

    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;
    localparam int YEAR_W  = 7;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    // Years are offsets from 2000; every multiple of four in 2000..2099 is leap.
    function automatic logic is_leap(input logic [YEAR_W-1:0] year);
        return (year % YEAR_W'(4)) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/day_counter_month_length.sv
`default_nettype none
// ============================================================================
// Module   : month_length
// Brief    : Combinational days-in-month lookup from month and year offset.
// Revision : 1.0 - initial release
// ============================================================================
module month_length #(
    parameter int DAY_W   = clock_cal_pkg::DAY_W,
    parameter int MONTH_W = clock_cal_pkg::MONTH_W,
    parameter int YEAR_W  = clock_cal_pkg::YEAR_W
) (
    input  logic [MONTH_W-1:0] month,
    input  logic [YEAR_W-1:0]  year,
    output logic [DAY_W-1:0]   dim
);
    import clock_cal_pkg::*;

    // Illegal months fall through to 31 so a loaded day is never falsely rejected.
    always_comb begin
        dim = DAY_W'(31);
        case (month)
            APR, JUN, SEP, NOV: dim = DAY_W'(30);
            FEB:                dim = is_leap(year) ? DAY_W'(29) : DAY_W'(28);
            default:            dim = DAY_W'(31);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/day_counter.sv
`default_nettype none
// ============================================================================
// Module   : day_counter
// Brief    : Day-of-month counter with month carry, load, set-increment, clamp.
// Revision : 1.0 - initial release
// ============================================================================
module day_counter #(
    parameter int DAY_W   = clock_cal_pkg::DAY_W,
    parameter int MONTH_W = clock_cal_pkg::MONTH_W,
    parameter int YEAR_W  = clock_cal_pkg::YEAR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               adj_up,
    input  logic               load,
    input  logic [DAY_W-1:0]   load_day,
    input  logic [MONTH_W-1:0] month,
    input  logic [YEAR_W-1:0]  year,
    output logic [DAY_W-1:0]   day,
    output logic               month_inc,
    output logic               load_err,
    output logic [DAY_W-1:0]   dim
);

    logic [DAY_W-1:0] day_q, day_d;
    logic             inc_q, inc_d;
    logic             err_q, err_d;
    logic             day_wrap;

    month_length #(
        .DAY_W   (DAY_W),
        .MONTH_W (MONTH_W),
        .YEAR_W  (YEAR_W)
    ) u_month_length (
        .month (month),
        .year  (year),
        .dim   (dim)
    );

    assign day_wrap = (day_q >= dim);

    // Exactly one action per edge: load, then tick, then adj_up, then clamp.
    always_comb begin
        day_d = day_q;
        inc_d = 1'b0;
        err_d = 1'b0;
        if (load) begin
            if ((load_day != '0) && (load_day <= dim)) begin
                day_d = load_day;
            end else begin
                err_d = 1'b1;
            end
        end else if (tick) begin
            if (day_wrap) begin
                day_d = DAY_W'(1);
                inc_d = 1'b1;
            end else begin
                day_d = day_q + DAY_W'(1);
            end
        end else if (adj_up) begin
            day_d = day_wrap ? DAY_W'(1) : day_q + DAY_W'(1);
        end else if (day_q > dim) begin
            day_d = dim;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_q <= DAY_W'(1);
            inc_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            day_q <= day_d;
            inc_q <= inc_d;
            err_q <= err_d;
        end
    end

    assign day       = day_q;
    assign month_inc = inc_q;
    assign load_err  = err_q;

endmodule
`default_nettype wire
